serial_result_collector: RTL and testbench

Downstream stage of the bit-serial adder. It gathers the LSB-first sum bit stream and the final carry, assembles each `WIDTH+1`-bit result word, and buffers completed words in a small FIFO. Words leave through a valid/ready handshake to the consumer (register file or test sink). It decouples the free-running serial datapath from a consumer that may stall.

---
 rtl/serial_pkg.sv | 18 +
 rtl/result_fifo.sv | 53 +++++
 rtl/serial_result_collector.sv | 101 ++++++++++
 tb/tb_serial_result_collector.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared types and constants for the serial adder result path.
package serial_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  // A result word carries the WIDTH sum bits plus the final carry on top.
  function automatic int res_width(input int w);
    return w + 1;
  endfunction

  localparam int DEFAULT_RES_W = res_width(DEFAULT_WIDTH);

endpackage

// File: rtl/result_fifo.sv
// DEPTH-entry synchronous FIFO for assembled result words; reports dropped pushes.
module result_fifo #(
  parameter int W     = 5,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head,
  output logic         drop
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CNW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [CNW-1:0]          count;
  logic                    push_ok, pop_ok;

  assign full    = (count == CNW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & ~push_ok;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNW'(1);
        2'b01:   count <= count - CNW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/serial_result_collector.sv
// Assembles LSB-first serial sum bits plus carry into words and buffers them for a stallable consumer.
module serial_result_collector
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_valid,
  input  logic             frame_start,
  input  logic             sum_bit,
  input  logic             carry_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH:0]   res_data,
  output logic             busy,
  output logic             overflow_err,
  output logic             frame_err
);

  localparam int RW = res_width(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d, sh_shift;
  logic [RW-1:0]    word;
  logic             push, ferr_set, drop, fifo_full, fifo_empty;

  assign sh_shift = {sum_bit, sh_q[WIDTH-1:1]};
  // The bit being accepted is the MSB; the older WIDTH-1 bits sit in the top of shreg.
  assign word     = {carry_in, sum_bit, sh_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    ferr_set = 1'b0;
    push     = 1'b0;
    if (bit_valid) begin
      case (state_q)
        S_IDLE: begin
          if (frame_start) begin
            sh_d    = sh_shift;
            cnt_d   = CW'(1);
            state_d = S_SHIFT;
          end else begin
            ferr_set = 1'b1;
          end
        end
        S_SHIFT: begin
          sh_d = sh_shift;
          if (frame_start) begin
            ferr_set = 1'b1;
            cnt_d    = CW'(1);
          end else if (cnt_q == CW'(WIDTH - 1)) begin
            push    = 1'b1;
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      sh_q         <= '0;
      overflow_err <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      if (drop)     overflow_err <= 1'b1;
      if (ferr_set) frame_err    <= 1'b1;
    end
  end

  result_fifo #(.W(RW), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (word),
    .pop       (res_ready),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (res_data),
    .drop      (drop)
  );

  assign res_valid = ~fifo_empty;
  assign busy      = (state_q == S_SHIFT);

endmodule

// File: tb/tb_serial_result_collector.sv
// Randomized + directed bench for serial_result_collector against a word-level queue model.
module tb_serial_result_collector;

  localparam int W = 4;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         bit_valid, frame_start, sum_bit, carry_in, res_ready;
  logic         res_valid, busy, overflow_err, frame_err;
  logic [W:0]   res_data;

  int vectors = 0;
  int miscompares = 0;

  // Model: bits collected so far in the current word, buffered words, sticky flags.
  int         m_nb;
  logic [W-1:0] m_pv;
  logic [W:0] m_q[$];
  bit         m_ovf, m_ferr;

  always #5 clk = ~clk;

  serial_result_collector #(.WIDTH(W), .DEPTH(D)) dut (
    .clk          (clk),
    .reset        (reset),
    .bit_valid    (bit_valid),
    .frame_start  (frame_start),
    .sum_bit      (sum_bit),
    .carry_in     (carry_in),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .busy         (busy),
    .overflow_err (overflow_err),
    .frame_err    (frame_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_nb = 0; m_pv = '0; m_q.delete(); m_ovf = 0; m_ferr = 0;
  endtask

  task automatic model_edge(input logic bv, fs, sb, cy, rdy);
    bit         do_push = 0;
    logic [W:0] w = '0;
    if (bv) begin
      if (fs) begin
        if (m_nb > 0) m_ferr = 1;
        m_pv = '0; m_pv[0] = sb; m_nb = 1;
      end else if (m_nb == 0) begin
        m_ferr = 1;
      end else begin
        m_pv[m_nb] = sb;
        m_nb++;
        if (m_nb == W) begin
          w = {cy, m_pv};
          do_push = 1;
          m_nb = 0;
        end
      end
    end
    if (rdy && m_q.size() != 0) void'(m_q.pop_front());
    if (do_push) begin
      if (m_q.size() < D) m_q.push_back(w);
      else m_ovf = 1;
    end
  endtask

  task automatic compare_all();
    chk("res_valid", 32'(res_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) chk("res_data", 32'(res_data), 32'(m_q[0]));
    chk("busy", 32'(busy), 32'(m_nb != 0));
    chk("overflow_err", 32'(overflow_err), 32'(m_ovf));
    chk("frame_err", 32'(frame_err), 32'(m_ferr));
  endtask

  // Inputs change at the falling edge; outputs are checked at the next falling edge.
  task automatic step(input logic bv, fs, sb, cy, rdy);
    bit_valid = bv; frame_start = fs; sum_bit = sb; carry_in = cy; res_ready = rdy;
    @(posedge clk);
    model_edge(bv, fs, sb, cy, rdy);
    @(negedge clk);
    compare_all();
  endtask

  task automatic send_word(input logic [W:0] v, input logic rdy, input int gap);
    for (int i = 0; i < W; i++) begin
      step(1'b1, i == 0, v[i], (i == W - 1) ? v[W] : 1'b0, rdy);
      if (i != W - 1)
        for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, 1'b0, rdy);
    end
  endtask

  task automatic async_reset();
    reset = 1'b1;
    #1;
    model_clear();
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_data", 32'(res_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(overflow_err), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; bit_valid = 0; frame_start = 0; sum_bit = 0; carry_in = 0; res_ready = 0;
    model_clear();
    @(negedge clk); @(negedge clk);
    async_reset();

    // 5+6 = 0b01011, visible one cycle after the 4th bit
    send_word(5'b01011, 1'b1, 0);
    chk("t1_valid", 32'(res_valid), 32'd1);
    chk("t1_data", 32'(res_data), 32'h0B);
    step(0, 0, 0, 0, 1);
    chk("t1_gone", 32'(res_valid), 32'd0);

    // 9+8 = 0b10001 with gaps; busy held across gaps
    step(1, 1, 1, 0, 1);
    chk("t2_busy_first", 32'(busy), 32'd1);
    step(0, 0, 0, 0, 1); step(1, 0, 0, 0, 1); step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("t2_busy_gap", 32'(busy), 32'd1);
    step(1, 0, 0, 1, 1);
    chk("t2_busy_end", 32'(busy), 32'd0);
    chk("t2_data", 32'(res_data), 32'h11);
    step(0, 0, 0, 0, 1);

    // Backpressure: third word dropped
    send_word(5'h0B, 1'b0, 0);
    send_word(5'h11, 1'b0, 1);
    send_word(5'h0F, 1'b0, 0);
    chk("t3_ovf", 32'(overflow_err), 32'd1);
    chk("t3_head_held", 32'(res_data), 32'h0B);
    step(0, 0, 0, 0, 1);
    chk("t3_second", 32'(res_data), 32'h11);
    step(0, 0, 0, 0, 1);
    chk("t3_drained", 32'(res_valid), 32'd0);

    // Framing: restart on 3rd bit, then stray bit in IDLE
    async_reset();
    step(1, 1, 0, 0, 0); step(1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    chk("t4_ferr", 32'(frame_err), 32'd1);
    step(1, 0, 0, 0, 0); step(1, 0, 1, 0, 0); step(1, 0, 1, 1, 0);
    chk("t4_word", 32'(res_data), 32'h1D);
    async_reset();
    step(1, 0, 1, 0, 0);
    chk("t4_idle_ferr", 32'(frame_err), 32'd1);
    chk("t4_idle_busy", 32'(busy), 32'd0);

    // Full FIFO with simultaneous pop and push
    async_reset();
    send_word(5'h03, 1'b0, 0);
    send_word(5'h15, 1'b0, 0);
    step(1, 1, 0, 0, 0); step(1, 0, 1, 0, 0); step(1, 0, 1, 0, 0);
    step(1, 0, 1, 1, 1);
    chk("t5_no_ovf", 32'(overflow_err), 32'd0);
    chk("t5_head", 32'(res_data), 32'h15);
    step(0, 0, 0, 0, 1);
    chk("t5_third", 32'(res_data), 32'h1E);
    chk("t5_still_valid", 32'(res_valid), 32'd1);
    step(0, 0, 0, 0, 1);

    // Reset mid-word with a word buffered
    send_word(5'h07, 1'b0, 0);
    step(1, 1, 1, 0, 0); step(1, 0, 1, 0, 0);
    async_reset();
    send_word(5'h16, 1'b1, 0);
    chk("t6_after", 32'(res_data), 32'h16);

    // Randomized phase
    for (int n = 0; n < 3000; n++) begin
      logic bv, fs;
      bv = ($urandom_range(0, 9) < 7);
      fs = (m_nb == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 499) == 0) async_reset();
      else step(bv, fs, 1'($urandom), 1'($urandom), ($urandom_range(0, 9) < 5));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
